// File: rtl/venmac_payout.sv
`default_nettype none
// ============================================================================
// venmac_payout : dispenser driver - one can-release pulse, then spaced coins
// Rev 1.0
// ============================================================================
module venmac_payout #(
  parameter int PULSE_GAP = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             can_in,
  input  logic [CNT_W-1:0] coin_in,
  output logic             busy,
  output logic             can_out,
  output logic             coin_pulse,
  output logic [CNT_W-1:0] coin_left,
  output logic             done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CAN  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int               GAP_W    = 4;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(PULSE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             can_q, can_d;
  logic             pulse_q, pulse_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      can_q   <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      armed_q <= armed_d;
      busy_q  <= busy_d;
      can_q   <= can_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  // cnt_q holds the coins still owed; it is decremented on entry to PAY so
  // it already shows the post-pulse value during the pulse cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    armed_d = armed_q;
    case (state_q)
      S_IDLE: begin
        if (!can_in) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          cnt_d   = coin_in;
          state_d = S_CAN;
        end
      end
      S_CAN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_PAY: begin
        state_d = S_GAP;
        gap_d   = GAP_LAST;
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PAY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    busy_d  = (state_d == S_CAN) || (state_d == S_PAY) || (state_d == S_GAP);
    can_d   = (state_d == S_CAN);
    pulse_d = (state_d == S_PAY);
    done_d  = (state_d == S_DONE);
  end

  assign busy       = busy_q;
  assign can_out    = can_q;
  assign coin_pulse = pulse_q;
  assign coin_left  = cnt_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_venmac_payout.sv
`default_nettype none
// ============================================================================
// tb_venmac_payout : directed + randomized bench with a timing-formula model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_venmac_payout;

  localparam int G = 2;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         can_in = 1'b0;
  logic [W-1:0] coin_in = '0;
  logic         busy, can_out, coin_pulse, done;
  logic [W-1:0] coin_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  venmac_payout #(.PULSE_GAP(G), .CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .can_in     (can_in),
    .coin_in    (coin_in),
    .busy       (busy),
    .can_out    (can_out),
    .coin_pulse (coin_pulse),
    .coin_left  (coin_left),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},       32'(busy),       0);
    chk({tag, " can_out"},    32'(can_out),    0);
    chk({tag, " coin_pulse"}, 32'(coin_pulse), 0);
    chk({tag, " done"},       32'(done),       0);
    chk({tag, " coin_left"},  32'(coin_left),  0);
  endtask

  function automatic int pulse_time(input int i);
    return 1 + i + (i - 1) * G;
  endfunction

  function automatic int done_time(input int n);
    return (n == 0) ? 2 : 2 + n * (G + 1);
  endfunction

  // Expected outputs t cycles after the accepting edge, from the timing rules.
  task automatic chk_vend_cycle(input int n, input int t);
    int  paid = 0;
    bit  p    = 1'b0;
    int  dt   = done_time(n);
    for (int i = 1; i <= n; i++) begin
      if (pulse_time(i) <= t) paid++;
      if (pulse_time(i) == t) p = 1'b1;
    end
    chk($sformatf("n%0d t%0d can_out", n, t),    32'(can_out),    32'(t == 1));
    chk($sformatf("n%0d t%0d coin_pulse", n, t), 32'(coin_pulse), 32'(p));
    chk($sformatf("n%0d t%0d coin_left", n, t),  32'(coin_left),  32'(n - paid));
    chk($sformatf("n%0d t%0d busy", n, t),       32'(busy),       32'(t >= 1 && t < dt));
    chk($sformatf("n%0d t%0d done", n, t),       32'(done),       32'(t == dt));
    chk($sformatf("n%0d t%0d exclusive", n, t),
        32'((32'(can_out) + 32'(coin_pulse) + 32'(done)) <= 1), 1);
  endtask

  task automatic idle_low(input int cycles);
    can_in = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk_idle("idle_low");
    end
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic run_vend(input int n, input bit hold, input int new_coin, input int stop_t);
    int dt = done_time(n);
    coin_in = W'(n);
    can_in  = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= dt + 1; t++) begin
      @(negedge clk);
      chk_vend_cycle(n, t);
      if (stop_t != 0 && t == stop_t) return;
      if (new_coin >= 0 && t == 2) coin_in = W'(new_coin);
      if (!hold && t == 3) can_in = 1'b0;
    end
  endtask

  initial begin
    // Reset with can_in stuck high, then stale high after release
    rst     = 1'b0;
    can_in  = 1'b1;
    coin_in = 4'd7;
    repeat (2) begin
      @(negedge clk);
      chk_idle("reset");
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_idle("stale_high");
    end

    idle_low(1);
    run_vend(3, 1'b0, -1, 0);

    idle_low(1);
    run_vend(0, 1'b0, -1, 0);

    idle_low(1);
    run_vend(15, 1'b0, int'($urandom_range(0, 15)), 0);

    for (int r = 0; r < 4; r++) begin
      idle_low(int'($urandom_range(1, 3)));
      run_vend(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), 0);
      can_in = 1'b0;
    end

    // can_in held past done must not retrigger
    idle_low(1);
    run_vend(int'($urandom_range(0, 15)), 1'b1, -1, 0);
    repeat (6) begin
      @(negedge clk);
      chk_idle("held_high");
    end
    idle_low(1);
    run_vend(1, 1'b0, 9, 0);

    // Reset one edge after the second pulse of a 5-coin payout
    idle_low(1);
    run_vend(5, 1'b1, -1, 5);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk_idle("post_abort");
    end
    idle_low(1);
    run_vend(5, 1'b0, -1, 0);
    idle_low(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
